// File: rtl/axi_sram_slave.sv
// AXI3-style single-transaction SRAM slave: word-addressed array, INCR bursts,
// configurable read latency, sticky WLAST/WID protocol error flag.
module axi_sram_slave #(
   parameter int    ADDR_WIDTH     = 26,
   parameter int    DATA_WIDTH     = 32,
   parameter int    MEM_WORDS_LOG2 = 14,
   parameter int    READ_LATENCY   = 4,
   parameter string INIT_FILE      = ""
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  AWVALID,
   output logic                  AWREADY,
   input  logic [3:0]            AWID,
   input  logic [3:0]            AWLEN,
   input  logic [ADDR_WIDTH-1:0] AWADDR,
   input  logic                  WVALID,
   output logic                  WREADY,
   input  logic                  WLAST,
   input  logic [3:0]            WID,
   input  logic [DATA_WIDTH-1:0] WDATA,
   output logic                  BVALID,
   input  logic                  BREADY,
   output logic [3:0]            BID,
   input  logic                  ARVALID,
   output logic                  ARREADY,
   input  logic [3:0]            ARID,
   input  logic [3:0]            ARLEN,
   input  logic [ADDR_WIDTH-1:0] ARADDR,
   output logic                  RVALID,
   input  logic                  RREADY,
   output logic                  RLAST,
   output logic [3:0]            RID,
   output logic [DATA_WIDTH-1:0] RDATA,
   output logic                  protocol_err
);

   localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam int IDX_W = MEM_WORDS_LOG2;

   typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BURST, WR_DATA, WR_RESP} state_t;

   state_t                state_q, state_d;
   logic [3:0]            id_q, id_d;
   logic [3:0]            rem_q, rem_d;
   logic [IDX_W-1:0]      addr_q, addr_d;
   logic [LAT_W-1:0]      lat_q, lat_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  perr_q, perr_d;
   logic                  mem_we, rd_en;
   logic [IDX_W-1:0]      rd_idx;

   logic [DATA_WIDTH-1:0] mem [2**IDX_W];

   generate
      if (ADDR_WIDTH > IDX_W) begin : g_hi_addr
         logic unused_addr_bits;
         assign unused_addr_bits = ^{AWADDR[ADDR_WIDTH-1:IDX_W], ARADDR[ADDR_WIDTH-1:IDX_W]};
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_q    <= '0;
         rem_q   <= '0;
         addr_q  <= '0;
         lat_q   <= '0;
         rdata_q <= '0;
         perr_q  <= 1'b0;
      end else begin
         id_q    <= id_d;
         rem_q   <= rem_d;
         addr_q  <= addr_d;
         lat_q   <= lat_d;
         rdata_q <= rdata_d;
         perr_q  <= perr_d;
      end
   end

   // Array is deliberately left out of reset so contents survive a reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem[addr_q] <= WDATA;
   end

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      rem_d   = rem_q;
      addr_d  = addr_q;
      lat_d   = lat_q;
      perr_d  = perr_q;
      mem_we  = 1'b0;
      rd_en   = 1'b0;
      rd_idx  = addr_q;
      case (state_q)
         IDLE: begin
            if (AWVALID) begin
               id_d    = AWID;
               addr_d  = AWADDR[IDX_W-1:0];
               rem_d   = AWLEN;
               state_d = WR_DATA;
            end else if (ARVALID) begin
               id_d   = ARID;
               addr_d = ARADDR[IDX_W-1:0];
               rem_d  = ARLEN;
               lat_d  = LAT_W'(READ_LATENCY - 1);
               if (READ_LATENCY == 1) begin
                  rd_en   = 1'b1;
                  rd_idx  = ARADDR[IDX_W-1:0];
                  state_d = RD_BURST;
               end else begin
                  state_d = RD_WAIT;
               end
            end
         end
         RD_WAIT: begin
            // Counter hits 0 on the edge that registers the first beat.
            lat_d = lat_q - LAT_W'(1);
            if (lat_q <= LAT_W'(1)) begin
               rd_en   = 1'b1;
               state_d = RD_BURST;
            end
         end
         RD_BURST: begin
            if (RREADY) begin
               if (rem_q == 4'd0) begin
                  state_d = IDLE;
               end else begin
                  addr_d = addr_q + IDX_W'(1);
                  rem_d  = rem_q - 4'd1;
                  rd_en  = 1'b1;
                  rd_idx = addr_q + IDX_W'(1);
               end
            end
         end
         WR_DATA: begin
            if (WVALID) begin
               mem_we = 1'b1;
               addr_d = addr_q + IDX_W'(1);
               if ((WLAST != (rem_q == 4'd0)) || (WID != id_q)) perr_d = 1'b1;
               if (rem_q == 4'd0) state_d = WR_RESP;
               else               rem_d   = rem_q - 4'd1;
            end
         end
         WR_RESP: begin
            if (BREADY) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      rdata_d = rd_en ? mem[rd_idx] : rdata_q;
   end

   // Ready outputs are gated by rst so they stay low throughout reset.
   always_comb begin
      AWREADY      = (state_q == IDLE) && !rst;
      ARREADY      = (state_q == IDLE) && !AWVALID && !rst;
      WREADY       = (state_q == WR_DATA);
      BVALID       = (state_q == WR_RESP);
      BID          = id_q;
      RVALID       = (state_q == RD_BURST);
      RLAST        = (state_q == RD_BURST) && (rem_q == 4'd0);
      RID          = id_q;
      RDATA        = rdata_q;
      protocol_err = perr_q;
   end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: stimulus pushes expected R/B responses into
// queues, an independent monitor pops and compares on each handshake.
module tb_axi_sram_slave;

   localparam int AW  = 26;
   localparam int DW  = 32;
   localparam int LAT = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          AWVALID = 0, AWREADY;
   logic [3:0]    AWID = 0, AWLEN = 0;
   logic [AW-1:0] AWADDR = 0;
   logic          WVALID = 0, WREADY, WLAST = 0;
   logic [3:0]    WID = 0;
   logic [DW-1:0] WDATA = 0;
   logic          BVALID, BREADY = 1'b1;
   logic [3:0]    BID;
   logic          ARVALID = 0, ARREADY;
   logic [3:0]    ARID = 0, ARLEN = 0;
   logic [AW-1:0] ARADDR = 0;
   logic          RVALID, RREADY = 0, RLAST;
   logic [3:0]    RID;
   logic [DW-1:0] RDATA;
   logic          protocol_err;

   axi_sram_slave #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS_LOG2(4),
      .READ_LATENCY(LAT), .INIT_FILE("")
   ) dut (
      .clk(clk), .rst(rst),
      .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWLEN(AWLEN), .AWADDR(AWADDR),
      .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST), .WID(WID), .WDATA(WDATA),
      .BVALID(BVALID), .BREADY(BREADY), .BID(BID),
      .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARLEN(ARLEN), .ARADDR(ARADDR),
      .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RID(RID), .RDATA(RDATA),
      .protocol_err(protocol_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]    id;
      logic [DW-1:0] data;
      logic          last;
   } rexp_t;

   rexp_t         rq[$];
   logic [3:0]    bq[$];
   logic [DW-1:0] mdl [16];
   logic [DW-1:0] wbuf [16];
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   logic          arready_at_aw;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: response scoreboard plus stall-stability checks.
   initial begin
      logic          prev_stall;
      logic [DW-1:0] prev_data;
      rexp_t         e;
      logic [3:0]    bexp;
      prev_stall = 1'b0;
      prev_data  = '0;
      forever begin
         @(negedge clk);
         if (!rst && prev_stall) begin
            chk("r_hold_valid", {31'd0, RVALID}, 32'd1);
            chk("r_hold_data", RDATA, prev_data);
         end
         prev_stall = RVALID && !RREADY && !rst;
         prev_data  = RDATA;
         if (RVALID && RREADY) begin
            if (rq.size() == 0) begin
               checks++; errors++;
               $display("FAIL r_unexpected: got beat %h with no expected beat", RDATA);
            end else begin
               e = rq.pop_front();
               chk("r_id", {28'd0, RID}, {28'd0, e.id});
               chk("r_data", RDATA, e.data);
               chk("r_last", {31'd0, RLAST}, {31'd0, e.last});
            end
         end
         if (BVALID && BREADY) begin
            if (bq.size() == 0) begin
               checks++; errors++;
               $display("FAIL b_unexpected: got BID %h with no expected response", BID);
            end else begin
               bexp = bq.pop_front();
               chk("b_id", {28'd0, BID}, {28'd0, bexp});
            end
         end
      end
   end

   task automatic do_write(input logic [3:0] id, input logic [AW-1:0] addr,
                           input logic [3:0] len, input int wlast_at);
      int         c0, n;
      logic [3:0] ix;
      AWVALID = 1'b1; AWID = id; AWADDR = addr; AWLEN = len;
      n = 0;
      @(negedge clk);
      while (!AWREADY && n < 50) begin n++; @(negedge clk); end
      chk("aw_handshake", {31'd0, AWREADY}, 32'd1);
      arready_at_aw = ARREADY;
      c0 = cyc;
      @(posedge clk); #1;
      AWVALID = 1'b0;
      for (int k = 0; k <= int'(len); k++) begin
         WVALID = 1'b1; WDATA = wbuf[k]; WID = id; WLAST = (k == wlast_at);
         ix = addr[3:0] + 4'(k);
         mdl[ix] = wbuf[k];
         n = 0;
         @(negedge clk);
         while (!WREADY && n < 50) begin n++; @(negedge clk); end
         chk("w_ready", {31'd0, WREADY}, 32'd1);
         @(posedge clk); #1;
      end
      WVALID = 1'b0; WLAST = 1'b0;
      bq.push_back(id);
      n = 0;
      @(negedge clk);
      while (!BVALID && n < 50) begin n++; @(negedge clk); end
      chk("b_cycle", cyc - c0, 32'(len) + 32'd2);
      @(posedge clk); #1;
   endtask

   task automatic do_read(input logic [3:0] id, input logic [AW-1:0] addr,
                          input logic [3:0] len, input int period, output int acc_wait);
      int         c0, n, i, first, lastc;
      logic       done;
      logic [3:0] ix;
      for (int k = 0; k <= int'(len); k++) begin
         ix = addr[3:0] + 4'(k);
         rq.push_back('{id: id, data: mdl[ix], last: (k == int'(len))});
      end
      ARVALID = 1'b1; ARID = id; ARADDR = addr; ARLEN = len;
      n = 0;
      @(negedge clk);
      while (!ARREADY && n < 50) begin n++; @(negedge clk); end
      chk("ar_handshake", {31'd0, ARREADY}, 32'd1);
      acc_wait = n;
      c0 = cyc;
      @(posedge clk); #1;
      ARVALID = 1'b0;
      first = -1; lastc = -1; done = 1'b0; i = 0;
      while (!done && i < 100) begin
         RREADY = ((i % period) == 0);
         @(negedge clk);
         if (RVALID && first < 0) first = cyc - c0;
         if (RVALID && RREADY && RLAST) begin done = 1'b1; lastc = cyc - c0; end
         @(posedge clk); #1;
         i++;
      end
      RREADY = 1'b0;
      chk("r_first_cycle", first, LAT);
      if (period == 1) chk("r_last_cycle", lastc, LAT + int'(len));
   endtask

   initial begin
      int w;
      // Reset state
      @(negedge clk);
      chk("rst_outs", {17'd0, AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST, protocol_err, RID, BID},
          32'd0);
      chk("rst_rdata", RDATA, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_awready", {31'd0, AWREADY}, 32'd1);
      chk("post_rst_arready", {31'd0, ARREADY}, 32'd1);
      @(posedge clk); #1;

      // Single read of a preloaded word
      wbuf[0] = 32'hDEADBEEF;
      do_write(4'd1, 26'h10, 4'd0, 0);
      do_read(4'd3, 26'h10, 4'd0, 1, w);

      // Burst write and readback
      for (int k = 0; k < 4; k++) wbuf[k] = 32'(k + 1);
      do_write(4'd5, 26'h20, 4'd3, 3);
      do_read(4'd6, 26'h20, 4'd3, 1, w);

      // Read backpressure, RREADY pattern 1,0,0,1,...
      for (int k = 0; k < 4; k++) wbuf[k] = 32'hA0 + 32'(k);
      do_write(4'd4, 26'h24, 4'd3, 3);
      do_read(4'd4, 26'h24, 4'd3, 3, w);

      // Simultaneous AR and AW: write must win
      ARVALID = 1'b1; ARID = 4'd8; ARADDR = 26'h8; ARLEN = 4'd1;
      wbuf[0] = 32'h77; wbuf[1] = 32'h78;
      do_write(4'd7, 26'h8, 4'd1, 1);
      chk("arready_blocked_by_aw", {31'd0, arready_at_aw}, 32'd0);
      do_read(4'd8, 26'h8, 4'd1, 1, w);
      chk("ar_accept_wait", w, 32'd0);

      // Early WLAST on a 4-beat write
      chk("perr_clear", {31'd0, protocol_err}, 32'd0);
      for (int k = 0; k < 4; k++) wbuf[k] = 32'hC0DE0000 + 32'(k);
      do_write(4'd2, 26'hA, 4'd3, 1);
      chk("perr_set", {31'd0, protocol_err}, 32'd1);
      do_read(4'd2, 26'hA, 4'd3, 1, w);
      chk("perr_sticky", {31'd0, protocol_err}, 32'd1);

      // Wrap across top of array; upper address bits ignored on readback
      wbuf[0] = 32'h1234; wbuf[1] = 32'h5678;
      do_write(4'd9, 26'hF, 4'd1, 1);
      do_read(4'd9, 26'h2F, 4'd1, 1, w);

      // Reset during RD_WAIT aborts the read without a response
      ARVALID = 1'b1; ARID = 4'd9; ARADDR = 26'h2F; ARLEN = 4'd1;
      @(negedge clk);
      chk("ar_before_rst", {31'd0, ARREADY}, 32'd1);
      @(posedge clk); #1 ARVALID = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      chk("midrst_outs", {17'd0, AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST, protocol_err, RID, BID},
          32'd0);
      chk("midrst_rdata", RDATA, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rerst_awready", {31'd0, AWREADY}, 32'd1);
      chk("rerst_arready", {31'd0, ARREADY}, 32'd1);
      @(posedge clk); #1;
      do_read(4'd9, 26'hF, 4'd1, 1, w);

      repeat (4) @(posedge clk);
      #1;
      chk("r_queue_drained", rq.size(), 32'd0);
      chk("b_queue_drained", bq.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
